// File: rtl/uart_tx_fifo_if.sv
// Byte-queue handshake between the bus side and the UART transmitter.
// The bus side drives the write strobe and byte; the transmitter reports space and fill level.
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

  logic               i_Tx_DV;
  logic [7:0]         i_Tx_Byte;
  logic               o_Tx_Ready;
  logic [COUNT_W-1:0] o_Fifo_Count;

  modport master (
    output i_Tx_DV,
    output i_Tx_Byte,
    input  o_Tx_Ready,
    input  o_Fifo_Count
  );

  modport slave (
    input  i_Tx_DV,
    input  i_Tx_Byte,
    output o_Tx_Ready,
    output o_Fifo_Count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO.
// Frames go out back-to-back while bytes are queued, with no idle gap between them.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          i_Clock,
  input  logic          reset,
  uart_tx_fifo_if.slave bus,
  output logic          o_Tx_Active,
  output logic          o_Tx_Serial,
  output logic          o_Tx_Done
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int COUNT_W = PTR_W + 1;
  localparam int CLK_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CLK_W-1:0]   LAST_CLK   = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  tx_state_t          state;
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [COUNT_W-1:0] count;
  logic [CLK_W-1:0]   clk_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift_reg;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               bit_end;

  // The FSM pops in IDLE, or on the last stop-bit edge to chain the next frame.
  assign fifo_empty       = (count == '0);
  assign bit_end          = (clk_cnt == LAST_CLK);
  assign push             = bus.i_Tx_DV && (count != FULL_COUNT);
  assign pop              = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign bus.o_Tx_Ready   = (count != FULL_COUNT);
  assign bus.o_Fifo_Count = count;

  always_ff @(posedge i_Clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.i_Tx_Byte;
    end
  end

  always_ff @(posedge i_Clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + COUNT_W'(1);
      end else if (pop && !push) begin
        count <= count - COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_Clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      o_Tx_Done <= 1'b0;
      case (state)
        IDLE: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
          clk_cnt     <= '0;
          if (!fifo_empty) begin
            shift_reg   <= fifo_mem[rd_ptr];
            o_Tx_Serial <= 1'b0;
            o_Tx_Active <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt     <= '0;
            bit_idx     <= '0;
            o_Tx_Serial <= shift_reg[0];
            state       <= DATA;
          end else begin
            clk_cnt <= clk_cnt + CLK_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              o_Tx_Serial <= 1'b1;
              state       <= STOP;
            end else begin
              bit_idx     <= bit_idx + 3'd1;
              o_Tx_Serial <= shift_reg[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + CLK_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt   <= '0;
            o_Tx_Done <= 1'b1;
            // A queued byte starts immediately so consecutive frames abut.
            if (!fifo_empty) begin
              shift_reg   <= fifo_mem[rd_ptr];
              o_Tx_Serial <= 1'b0;
              state       <= START;
            end else begin
              o_Tx_Active <= 1'b0;
              state       <= IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + CLK_W'(1);
          end
        end
        default: begin
          state       <= IDLE;
          clk_cnt     <= '0;
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 8 clocks per bit with a 4-entry FIFO.
// A negedge line monitor decodes frames and logs start and done times for the checks.
module tb_uart_tx_fifo;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic i_Clock;
  logic reset;
  logic o_Tx_Active;
  logic o_Tx_Serial;
  logic o_Tx_Done;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [9:0] frame_q [$];
  int         start_q [$];
  int         done_q  [$];
  logic       mon_busy = 1'b0;
  int         mon_off  = 0;
  int         mon_start = 0;
  logic [9:0] mon_bits = '0;

  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_Clock    (i_Clock),
    .reset      (reset),
    .bus        (bus),
    .o_Tx_Active(o_Tx_Active),
    .o_Tx_Serial(o_Tx_Serial),
    .o_Tx_Done  (o_Tx_Done)
  );

  initial begin
    i_Clock = 1'b0;
    forever #5 i_Clock = ~i_Clock;
  end

  initial begin
    forever begin
      @(posedge i_Clock);
      cyc++;
    end
  end

  // Frame decoder: samples each bit at its centre, starting from the first low level seen.
  initial begin
    forever begin
      @(negedge i_Clock);
      if (reset !== 1'b1) begin
        mon_busy = 1'b0;
      end else begin
        if (o_Tx_Done === 1'b1) done_q.push_back(cyc);
        if (!mon_busy) begin
          if (o_Tx_Serial === 1'b0) begin
            mon_busy  = 1'b1;
            mon_off   = 0;
            mon_start = cyc;
            mon_bits  = '0;
          end
        end else begin
          mon_off++;
        end
        if (mon_busy && ((mon_off % CPB) == CPB / 2)) mon_bits[4'(mon_off / CPB)] = o_Tx_Serial;
        if (mon_busy && (mon_off == 9 * CPB + CPB / 2)) begin
          frame_q.push_back(mon_bits);
          start_q.push_back(mon_start);
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle(input int n);
    repeat (n) begin
      @(posedge i_Clock);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic dv, input logic [7:0] data);
    bus.i_Tx_DV   = dv;
    bus.i_Tx_Byte = data;
    stepCycle(1);
  endtask

  task automatic idleWatch(input int n, output int lows);
    lows = 0;
    repeat (n) begin
      stepCycle(1);
      if (o_Tx_Serial !== 1'b1) lows++;
    end
  endtask

  task automatic clearLog();
    frame_q.delete();
    start_q.delete();
    done_q.delete();
  endtask

  task automatic expectFrame(input string tag, input logic [9:0] expected);
    checkOutput({tag, "_seen"}, 32'(frame_q.size() > 0), 32'd1);
    if (frame_q.size() > 0) checkOutput(tag, 32'(frame_q.pop_front()), 32'(expected));
  endtask

  function automatic int startGap(input int i);
    return (start_q.size() > i) ? start_q[i] - start_q[i-1] : -1;
  endfunction

  function automatic int doneGap(input int i);
    return (done_q.size() > i) ? done_q[i] - done_q[i-1] : -1;
  endfunction

  initial begin
    int lows;
    int peak;
    logic [2:0] cnt_log [6];
    logic       rdy_log [6];

    reset         = 1'b0;
    bus.i_Tx_DV   = 1'b0;
    bus.i_Tx_Byte = 8'h00;

    stepCycle(3);
    checkOutput("rst_serial", 32'(o_Tx_Serial), 32'd1);
    checkOutput("rst_active", 32'(o_Tx_Active), 32'd0);
    checkOutput("rst_done", 32'(o_Tx_Done), 32'd0);
    checkOutput("rst_count", 32'(bus.o_Fifo_Count), 32'd0);
    checkOutput("rst_ready", 32'(bus.o_Tx_Ready), 32'd1);

    reset = 1'b1;
    idleWatch(40, lows);
    checkOutput("idle_low_cycles", 32'(lows), 32'd0);
    checkOutput("idle_frames", 32'(frame_q.size()), 32'd0);

    $display("[TB] single byte 0xA5");
    clearLog();
    applyStimulus(1'b1, 8'hA5);
    checkOutput("a5_serial_at_push", 32'(o_Tx_Serial), 32'd1);
    checkOutput("a5_count_at_push", 32'(bus.o_Fifo_Count), 32'd1);
    applyStimulus(1'b0, 8'h00);
    checkOutput("a5_start_latency", 32'(o_Tx_Serial), 32'd0);
    checkOutput("a5_active", 32'(o_Tx_Active), 32'd1);
    checkOutput("a5_count_popped", 32'(bus.o_Fifo_Count), 32'd0);
    stepCycle(85);
    expectFrame("a5_frame", 10'h34A);
    checkOutput("a5_done_pulses", 32'(done_q.size()), 32'd1);
    checkOutput("a5_frame_len", 32'((done_q.size() > 0 && start_q.size() > 0) ? done_q[0] - start_q[0] : -1), 32'd80);
    checkOutput("a5_active_drop", 32'(o_Tx_Active), 32'd0);
    checkOutput("a5_idle_line", 32'(o_Tx_Serial), 32'd1);

    $display("[TB] three back-to-back bytes");
    clearLog();
    peak = 0;
    applyStimulus(1'b1, 8'h00);
    if (int'(bus.o_Fifo_Count) > peak) peak = int'(bus.o_Fifo_Count);
    applyStimulus(1'b1, 8'hFF);
    if (int'(bus.o_Fifo_Count) > peak) peak = int'(bus.o_Fifo_Count);
    applyStimulus(1'b1, 8'h3C);
    if (int'(bus.o_Fifo_Count) > peak) peak = int'(bus.o_Fifo_Count);
    bus.i_Tx_DV = 1'b0;
    checkOutput("b2b_peak_count", 32'(peak), 32'd2);
    stepCycle(250);
    expectFrame("b2b_frame0", 10'h200);
    expectFrame("b2b_frame1", 10'h3FE);
    expectFrame("b2b_frame2", 10'h278);
    checkOutput("b2b_gap01", 32'(startGap(1)), 32'd80);
    checkOutput("b2b_gap12", 32'(startGap(2)), 32'd80);
    checkOutput("b2b_done_pulses", 32'(done_q.size()), 32'd3);
    checkOutput("b2b_done_gap01", 32'(doneGap(1)), 32'd80);
    checkOutput("b2b_done_gap12", 32'(doneGap(2)), 32'd80);

    $display("[TB] overflow with a frame active");
    clearLog();
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'(2 + i));
      cnt_log[i] = bus.o_Fifo_Count;
      rdy_log[i] = bus.o_Tx_Ready;
    end
    bus.i_Tx_DV = 1'b0;
    checkOutput("ovf_ready_at_3", 32'(rdy_log[2]), 32'd1);
    checkOutput("ovf_count_at_4", 32'(cnt_log[3]), 32'd4);
    checkOutput("ovf_ready_at_4", 32'(rdy_log[3]), 32'd0);
    checkOutput("ovf_count_after_6", 32'(cnt_log[5]), 32'd4);
    stepCycle(410);
    checkOutput("ovf_frame_count", 32'(frame_q.size()), 32'd5);
    expectFrame("ovf_frame0", 10'h202);
    expectFrame("ovf_frame1", 10'h204);
    expectFrame("ovf_frame2", 10'h206);
    expectFrame("ovf_frame3", 10'h208);
    expectFrame("ovf_frame4", 10'h20A);
    checkOutput("ovf_count_drained", 32'(bus.o_Fifo_Count), 32'd0);
    checkOutput("ovf_ready_drained", 32'(bus.o_Tx_Ready), 32'd1);

    $display("[TB] push on the stop-bit pop edge");
    clearLog();
    applyStimulus(1'b1, 8'h22);
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b1, 8'h33);
    bus.i_Tx_DV = 1'b0;
    stepCycle(78);
    applyStimulus(1'b1, 8'h11);
    bus.i_Tx_DV = 1'b0;
    checkOutput("sim_done_edge", 32'(o_Tx_Done), 32'd1);
    checkOutput("sim_count", 32'(bus.o_Fifo_Count), 32'd1);
    checkOutput("sim_next_start", 32'(o_Tx_Serial), 32'd0);
    checkOutput("sim_active", 32'(o_Tx_Active), 32'd1);
    stepCycle(175);
    expectFrame("sim_frame0", 10'h244);
    expectFrame("sim_frame1", 10'h266);
    expectFrame("sim_frame2", 10'h222);
    checkOutput("sim_gap01", 32'(startGap(1)), 32'd80);
    checkOutput("sim_gap12", 32'(startGap(2)), 32'd80);
    checkOutput("sim_count_drained", 32'(bus.o_Fifo_Count), 32'd0);

    $display("[TB] reset during a data bit");
    clearLog();
    applyStimulus(1'b1, 8'h55);
    applyStimulus(1'b1, 8'h66);
    applyStimulus(1'b1, 8'h77);
    bus.i_Tx_DV = 1'b0;
    checkOutput("mid_count_queued", 32'(bus.o_Fifo_Count), 32'd2);
    stepCycle(33);
    checkOutput("mid_bit3_low", 32'(o_Tx_Serial), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_serial", 32'(o_Tx_Serial), 32'd1);
    checkOutput("mid_rst_active", 32'(o_Tx_Active), 32'd0);
    checkOutput("mid_rst_count", 32'(bus.o_Fifo_Count), 32'd0);
    checkOutput("mid_rst_ready", 32'(bus.o_Tx_Ready), 32'd1);
    stepCycle(3);
    reset = 1'b1;
    clearLog();
    idleWatch(30, lows);
    checkOutput("post_rst_low_cycles", 32'(lows), 32'd0);
    checkOutput("post_rst_frames", 32'(frame_q.size()), 32'd0);
    applyStimulus(1'b1, 8'h81);
    bus.i_Tx_DV = 1'b0;
    stepCycle(90);
    expectFrame("post_rst_frame", 10'h302);
    checkOutput("post_rst_done_pulses", 32'(done_q.size()), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
UART transmitter for the FPGC IO subsystem and the transmit-side counterpart of the existing UART receiver. The line format is 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity. A small internal FIFO lets the CPU/bus side queue bytes without waiting per character. The serial output drives the board TX pin directly.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per bit (i_Clock freq / baud); legal range 2..65535.
- FIFO_DEPTH, 4, FIFO entries; must be a power of 2, minimum 2.

Ports:
- i_Clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- i_Tx_DV  in  1  write strobe; pushes i_Tx_Byte on a rising edge when o_Tx_Ready=1.
- i_Tx_Byte  in  8  byte to queue.
- o_Tx_Ready  out  1  FIFO not full (combinational from the registered count).
- o_Fifo_Count  out  clog2(FIFO_DEPTH)+1  number of queued bytes, excluding the byte being shifted.
- o_Tx_Active  out  1  high while a frame (START, DATA or STOP) is on the line.
- o_Tx_Serial  out  1  serial line; registered; idle high.
- o_Tx_Done  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset (reset=0, asynchronous):
  - o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Fifo_Count=0, o_Tx_Ready=1.
  - FSM goes to IDLE; FIFO pointers clear.
  - A frame in progress is aborted and the line goes high immediately. Queued bytes are discarded.
  - Deassertion is synchronous-safe: the first active edge after release is treated as IDLE.
- FIFO:
  - A push occurs when i_Tx_DV=1 and the FIFO is not full at the edge.
  - A write while full is dropped silently; count and contents are unchanged.
  - Push and pop on the same edge (FIFO not full) both occur; the count is unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states and transitions:
  - IDLE:
    - o_Tx_Serial=1, o_Tx_Active=0.
    - If the FIFO is non-empty at an edge: pop the head into the shift register, drive o_Tx_Serial=0, set o_Tx_Active=1, clear the bit counter, go to START.
    - A byte pushed into an empty FIFO at edge N is popped at edge N+1, so the start bit begins after edge N+1.
  - START:
    - Hold 0 for exactly CLKS_PER_BIT cycles.
    - Then drive bit 0 and go to DATA.
  - DATA:
    - Each bit is held CLKS_PER_BIT cycles, LSB first, with a 3-bit index.
    - After bit 7's period, drive 1 and go to STOP.
  - STOP:
    - Hold 1 for CLKS_PER_BIT cycles.
    - At the final edge, pulse o_Tx_Done high for exactly one cycle.
    - If the FIFO is non-empty at that same edge: pop, drive 0 and go to START. This gives back-to-back frames with no idle gap, and o_Tx_Active stays 1.
    - Otherwise go to IDLE with o_Tx_Active=0.
  - Illegal state encodings return to IDLE.
- Timing:
  - Every frame is exactly 10*CLKS_PER_BIT cycles.
  - The bit counter is wide enough for CLKS_PER_BIT-1 and counts 0..CLKS_PER_BIT-1 per bit.
- The byte being shifted is held in the shift register. FIFO writes during a frame never alter it.

Test Plan:
1. Use CLKS_PER_BIT=8 throughout. Reset low mid-sim:
   - During reset: o_Tx_Serial=1, o_Tx_Active=0, o_Fifo_Count=0, o_Tx_Ready=1.
   - After release: line stays high indefinitely with no writes.
2. Push 0xA5 once while idle:
   - o_Tx_Serial goes low one cycle after the push edge.
   - Sampling at bit centres yields 0,1,0,1,0,0,1,0,1,1.
   - Each level lasts 8 cycles; total 80 cycles.
   - o_Tx_Done pulses once at cycle 80; o_Tx_Active then drops.
3. Push 0x00, 0xFF, 0x3C on consecutive cycles:
   - o_Fifo_Count peaks at 2.
   - Three frames appear with no idle cycles between the stop bit and the next start bit.
   - Exactly 3 o_Tx_Done pulses, 80 cycles apart.
4. Overflow: with a frame active and FIFO_DEPTH=4, push 6 bytes in 6 cycles:
   - First 4 are accepted; o_Tx_Ready drops at count 4.
   - Bytes 5 and 6 are dropped; only the first 5 bytes (the active one plus 4 queued) are transmitted.
5. Simultaneous push and pop:
   - Push 0x11 on the same edge the STOP state pops the last queued byte.
   - Count stays consistent; 0x11 is transmitted next without a gap.
6. Assert reset during data bit 3 of 0x55 with 2 bytes queued:
   - Line goes high asynchronously; count becomes 0.
   - After release no frame starts; a new 0x81 push transmits correctly.
